// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-side program-counter stage.
// The TRAP state is only reachable when PC_MISALIGN_TRAP_EN is defined.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_TRAP = 2'd3
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_INC    = 2'd1,
    SEL_TARGET = 2'd2,
    SEL_PEND   = 2'd3
  } pc_sel_t;

  localparam logic [31:0] PC_INC                   = 32'd4;
  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT  = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector driven by the pc_unit FSM select code.
// Without PC_MISALIGN_TRAP_EN, redirect targets are forced word-aligned.
module pc_next_mux
  import pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] target,
  input  logic [31:0] pend_target,
  input  pc_sel_t     sel,
  output logic [31:0] next_pc
);

`ifdef PC_MISALIGN_TRAP_EN
  // Misaligned targets never reach this mux; they divert to TRAP instead.
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
`endif

  // Select the value loaded into the PC register at the next edge.
  always_comb begin
    next_pc = pc;
    case (sel)
      SEL_HOLD:   next_pc = pc;
      SEL_INC:    next_pc = pc_plus4;
      SEL_TARGET: next_pc = target & ALIGN_MASK;
      SEL_PEND:   next_pc = pend_target & ALIGN_MASK;
      default:    next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-side PC register, redirect/flush control and imem request.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR_DEFAULT
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  input  logic        IMEM_BUSYWAIT,
  output logic        IMEM_READ,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        FLUSH,
  output logic        MISALIGN
);

  pc_state_t   state_r;
  pc_state_t   next_state_s;
  pc_sel_t     sel_s;
  logic [31:0] pc_r;
  logic [31:0] pend_r;
  logic [31:0] next_pc_s;
  logic        imem_read_r;
  logic        flush_s;
  logic        capture_s;

  assign PC        = pc_r;
  assign PC_PLUS4  = pc_r + PC_INC;
  assign IMEM_READ = imem_read_r;
  assign FLUSH     = flush_s;

  pc_next_mux u_next_mux (
    .pc          (pc_r),
    .pc_plus4    (PC_PLUS4),
    .target      (BRANCH_TARGET),
    .pend_target (pend_r),
    .sel         (sel_s),
    .next_pc     (next_pc_s)
  );

  // Next-state, PC select and flush decode; a taken branch outranks busywait-hold and stall.
  always_comb begin
    next_state_s = state_r;
    sel_s        = SEL_HOLD;
    flush_s      = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_BOOT: begin
        next_state_s = ST_RUN;
      end
      ST_RUN: begin
        if (BRANCH_TAKEN && !IMEM_BUSYWAIT) begin
          flush_s = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
          if (is_misaligned(BRANCH_TARGET)) begin
            next_state_s = ST_TRAP;
            sel_s        = SEL_HOLD;
          end else begin
            sel_s = SEL_TARGET;
          end
`else
          sel_s = SEL_TARGET;
`endif
        end else if (BRANCH_TAKEN) begin
          // Redirect cannot issue while imem is busy; park it until busywait drops.
          capture_s    = 1'b1;
          next_state_s = ST_PEND;
        end else if (IMEM_BUSYWAIT || STALL) begin
          sel_s = SEL_HOLD;
        end else begin
          sel_s = SEL_INC;
        end
      end
      ST_PEND: begin
        if (!IMEM_BUSYWAIT) begin
          flush_s      = 1'b1;
          next_state_s = ST_RUN;
`ifdef PC_MISALIGN_TRAP_EN
          if (is_misaligned(pend_r)) begin
            next_state_s = ST_TRAP;
            sel_s        = SEL_HOLD;
          end else begin
            sel_s = SEL_PEND;
          end
`else
          sel_s = SEL_PEND;
`endif
        end else begin
          sel_s = SEL_HOLD;
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      ST_TRAP: begin
        next_state_s = ST_TRAP;
      end
`endif
      default: begin
        next_state_s = ST_BOOT;
      end
    endcase
  end

  // State, PC, pending target and registered fetch request.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_BOOT;
      pc_r        <= RESET_VECTOR;
      pend_r      <= 32'h0000_0000;
      imem_read_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      pc_r        <= next_pc_s;
      imem_read_r <= (next_state_s == ST_RUN) || (next_state_s == ST_PEND);
      if (capture_s) begin
        pend_r <= BRANCH_TARGET;
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_r;

  // Sticky trap flag; only reset clears it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      misalign_r <= 1'b0;
    end else if (next_state_s == ST_TRAP) begin
      misalign_r <= 1'b1;
    end
  end

  assign MISALIGN = misalign_r;
`else
  assign MISALIGN = 1'b0;
`endif

endmodule
